// File: rtl/alu_pkg.sv
// Shared opcode definitions and width defaults for the shared-ALU arbiter slice.
package alu_pkg;

    localparam int WIDTH_DEFAULT = 64;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_ADD = 3'b011,
        OP_SUB = 3'b100
    } op_e;

    localparam logic [2:0] OP_ILLEGAL_LO = 3'b101;
    localparam logic [2:0] OP_ILLEGAL_HI = 3'b111;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    function automatic logic op_is_illegal(input logic [2:0] op);
        return (op >= OP_ILLEGAL_LO) && (op <= OP_ILLEGAL_HI);
    endfunction

endpackage

// File: rtl/alu_core_64bit.sv
// Combinational opcode decode and arithmetic; illegal opcodes give zero with err set.
module alu_core_64bit
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] Out,
    output logic             err
);

    always_comb begin
        Out = '0;
        err = op_is_illegal(op);
        case (op)
            OP_AND:  Out = A & B;
            OP_OR:   Out = A | B;
            OP_XOR:  Out = A ^ B;
            OP_ADD:  Out = A + B;
            OP_SUB:  Out = A - B;
            default: Out = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared ALU with a single result register.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 first); default is round-robin.
//
//   state    | meaning
//   ---------+-------------------------------------------
//   ST_EMPTY | result register empty, res_valid low
//   ST_FULL  | result register holds a result, res_valid high
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             res_err,
    output logic [CNT_W-1:0] op_count
);

    state_e             state_q;
    logic [WIDTH-1:0]   res_data_q;
    logic               res_id_q;
    logic               res_err_q;
    logic [CNT_W-1:0]   op_count_q;

    logic               grant0;
    logic               grant1;
    logic               can_accept;
    logic               accept;
    logic               sel;
    logic [2:0]         alu_op;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [WIDTH-1:0]   alu_out;
    logic               alu_err;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant0 = req0_valid;
    assign grant1 = req1_valid & ~req0_valid;
`else
    logic last_grant_q;

    // On contention the requester that did not win last time goes first.
    assign grant0 = req0_valid & (~req1_valid | last_grant_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);
`endif

    assign can_accept = (state_q == ST_EMPTY) | res_ready;
    assign req0_ready = grant0 & can_accept & ~rst;
    assign req1_ready = grant1 & can_accept & ~rst;
    assign accept     = req0_ready | req1_ready;
    assign sel        = req1_ready;

    assign alu_op = sel ? req1_op : req0_op;
    assign alu_a  = sel ? req1_a  : req0_a;
    assign alu_b  = sel ? req1_b  : req0_b;

    alu_core_64bit #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .A   (alu_a),
        .B   (alu_b),
        .op  (alu_op),
        .Out (alu_out),
        .err (alu_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
            res_err_q  <= 1'b0;
            op_count_q <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            if (accept) begin
                state_q    <= ST_FULL;
                res_data_q <= alu_out;
                res_id_q   <= sel;
                res_err_q  <= alu_err;
`ifndef ALU_ARB_FIXED_PRIO_EN
                last_grant_q <= sel;
`endif
            end else if (res_ready) begin
                state_q <= ST_EMPTY;
            end
            if ((state_q == ST_FULL) && res_ready) begin
                op_count_q <= op_count_q + CNT_W'(1);
            end
        end
    end

    assign res_valid = (state_q == ST_FULL);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_err   = res_err_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter (CNT_W=4 so counter wrap is reachable).
module tb_alu_share_arbiter;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic        res_valid, res_ready;
    logic [63:0] res_data;
    logic        res_id, res_err;
    logic [3:0]  op_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(64), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_err    (res_err),
        .op_count   (op_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = '0; req0_b = '0;
        req1_valid = 1'b1; req1_op = 3'b000; req1_a = '0; req1_b = '0;
        res_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (res_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", res_valid); else n_pass++;
        n_checks++; if (res_data !== 64'h0) $display("FAIL reset_data got %h want 0", res_data); else n_pass++;
        n_checks++; if (res_id !== 1'b0) $display("FAIL reset_id got %b want 0", res_id); else n_pass++;
        n_checks++; if (res_err !== 1'b0) $display("FAIL reset_err got %b want 0", res_err); else n_pass++;
        n_checks++; if (op_count !== 4'd0) $display("FAIL reset_count got %0d want 0", op_count); else n_pass++;
        n_checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_readies got %b want 00", {req0_ready, req1_ready}); else n_pass++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_and_basic();
        req0_valid = 1'b1; req0_op = 3'b000;
        req0_a = 64'hFF00FF00FF00FF00; req0_b = 64'h0F0F0F0F0F0F0F0F;
        res_ready = 1'b1;
        #1;
        n_checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL and_readies got %b want 10", {req0_ready, req1_ready}); else n_pass++;
        tick();
        req0_valid = 1'b0;
        n_checks++; if (res_valid !== 1'b1) $display("FAIL and_valid got %b want 1", res_valid); else n_pass++;
        n_checks++; if (res_data !== 64'h0F000F000F000F00) $display("FAIL and_data got %h want 0f000f000f000f00", res_data); else n_pass++;
        n_checks++; if ({res_id, res_err} !== 2'b00) $display("FAIL and_id_err got %b want 00", {res_id, res_err}); else n_pass++;
        tick();
        n_checks++; if (op_count !== 4'd1) $display("FAIL and_count got %0d want 1", op_count); else n_pass++;
        n_checks++; if (res_valid !== 1'b0) $display("FAIL and_drain got %b want 0", res_valid); else n_pass++;
    endtask

    task automatic test_contention();
        logic        exp_g;
        logic [63:0] exp_d;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_op = 3'b011; req0_a = 64'd1; req0_b = 64'd2;
        req1_valid = 1'b1; req1_op = 3'b100; req1_a = 64'd5; req1_b = 64'd7;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_g = FIXED ? 1'b0 : i[0];
            exp_d = exp_g ? 64'hFFFFFFFFFFFFFFFE : 64'h3;
            #1;
            n_checks++; if ({req0_ready, req1_ready} !== {~exp_g, exp_g}) $display("FAIL cont_grant[%0d] got %b want %b", i, {req0_ready, req1_ready}, {~exp_g, exp_g}); else n_pass++;
            tick();
            n_checks++; if ({res_valid, res_id} !== {1'b1, exp_g}) $display("FAIL cont_id[%0d] got %b want %b", i, {res_valid, res_id}, {1'b1, exp_g}); else n_pass++;
            n_checks++; if (res_data !== exp_d) $display("FAIL cont_data[%0d] got %h want %h", i, res_data, exp_d); else n_pass++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        n_checks++; if ({res_valid, op_count} !== {1'b0, 4'd4}) $display("FAIL cont_count got %b/%0d want 0/4", res_valid, op_count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        req0_valid = 1'b1; req0_op = 3'b010; req0_a = 64'hAA; req0_b = 64'h55;
        res_ready = 1'b0;
        #1;
        n_checks++; if (req0_ready !== 1'b1) $display("FAIL bp_first_ready got %b want 1", req0_ready); else n_pass++;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 3'b011; req1_a = 64'd10; req1_b = 64'd20;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL bp_readies[%0d] got %b want 00", i, {req0_ready, req1_ready}); else n_pass++;
            n_checks++; if ({res_valid, res_id, res_err, res_data} !== {3'b100, 64'hFF}) $display("FAIL bp_hold[%0d] got %b%b%b %h want 100 ff", i, res_valid, res_id, res_err, res_data); else n_pass++;
            tick();
        end
        res_ready = 1'b1;
        #1;
        n_checks++; if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL bp_release got %b want 01", {req0_ready, req1_ready}); else n_pass++;
        tick();
        req1_valid = 1'b0;
        n_checks++; if ({res_valid, res_id, res_data} !== {2'b11, 64'h1E}) $display("FAIL bp_b2b got %b%b %h want 11 1e", res_valid, res_id, res_data); else n_pass++;
        tick();
        n_checks++; if ({res_valid, op_count} !== {1'b0, 4'd6}) $display("FAIL bp_count got %b/%0d want 0/6", res_valid, op_count); else n_pass++;
    endtask

    task automatic test_illegal();
        logic [2:0]  ops   [3] = '{3'b101, 3'b110, 3'b011};
        logic [63:0] avals [3] = '{64'h1234, 64'hFFFF, 64'hFFFFFFFFFFFFFFFF};
        logic        errs  [3] = '{1'b1, 1'b1, 1'b0};
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_b = 64'd1;
        for (int i = 0; i < 3; i++) begin
            req0_op = ops[i];
            req0_a  = avals[i];
            #1;
            n_checks++; if (req0_ready !== 1'b1) $display("FAIL ill_ready[%0d] got %b want 1", i, req0_ready); else n_pass++;
            tick();
            n_checks++; if ({res_valid, res_err, res_data} !== {1'b1, errs[i], 64'h0}) $display("FAIL ill_result[%0d] got %b%b %h want 1%b 0", i, res_valid, res_err, res_data, errs[i]); else n_pass++;
        end
        req0_valid = 1'b0;
        tick();
        n_checks++; if (op_count !== 4'd9) $display("FAIL ill_count got %0d want 9", op_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1; req0_op = 3'b001; req0_a = 64'hF0; req0_b = 64'h0F;
        res_ready = 1'b0;
        tick();
        req0_valid = 1'b0;
        n_checks++; if ({res_valid, res_data} !== {1'b1, 64'hFF}) $display("FAIL mid_full got %b %h want 1 ff", res_valid, res_data); else n_pass++;
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        #1;
        n_checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL mid_rst_readies got %b want 00", {req0_ready, req1_ready}); else n_pass++;
        tick();
        rst = 1'b0;
        n_checks++; if ({res_valid, op_count} !== {1'b0, 4'd0}) $display("FAIL mid_cleared got %b/%0d want 0/0", res_valid, op_count); else n_pass++;
        #1;
        n_checks++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL mid_first_grant got %b want 10", {req0_ready, req1_ready}); else n_pass++;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_checks++; if ({res_valid, res_id} !== 2'b10) $display("FAIL mid_first_id got %b want 10", {res_valid, res_id}); else n_pass++;
        tick();
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_op = 3'b011; req0_a = 64'd3; req0_b = 64'd4;
        res_ready = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        req0_valid = 1'b0;
        n_checks++; if (op_count !== 4'd15) $display("FAIL wrap_pre got %0d want 15", op_count); else n_pass++;
        tick();
        n_checks++; if ({res_valid, op_count} !== {1'b0, 4'd0}) $display("FAIL wrap_zero got %b/%0d want 0/0", res_valid, op_count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_and_basic();
        test_contention();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
